// File: rtl/preempt_pkg.sv
// -----------------------------------------------------------------------------
// preempt_pkg
// Shared definitions for the emergency-vehicle preemption arbiter.
//   - 2-bit state encodings and the FSM state enum
//   - idx_width(): width of an index into an N-wide request vector
// -----------------------------------------------------------------------------
package preempt_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_ACK = ST_WAIT_ACK,
        HOLD     = ST_HOLD,
        RELEASE  = ST_RELEASE
    } state_e;

    // Index width for n requesters; never below 1 bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker: returns the first set request bit
// scanning ptr_i, ptr_i+1, ... wrapping modulo N. Fixed priority is obtained
// by tying ptr_i to zero.
// Ports:
//   req_i    [N]   request vector
//   ptr_i    [IW]  index with highest priority this cycle (must be < N)
//   found_o        any request set
//   winner_o [IW]  index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module rr_pick
    import preempt_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]              req_i,
    input  logic [idx_width(N)-1:0]   ptr_i,
    output logic                      found_o,
    output logic [idx_width(N)-1:0]   winner_o
);

    localparam int IW = idx_width(N);

    // cand[k] is the index examined at scan offset k; wrap is a compare against
    // N rather than a mask so non-power-of-two N works.
    logic [IW:0]   sum  [N];
    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr_i} + (IW+1)'(gi);
        assign cand[gi] = (sum[gi] >= (IW+1)'(N)) ? IW'(sum[gi] - (IW+1)'(N))
                                                  : IW'(sum[gi]);
        assign hit[gi]  = req_i[cand[gi]];
    end

    assign found_o = |hit;

    // Walk offsets from far to near so the smallest offset wins.
    always_comb begin
        winner_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/preempt_arbiter.sv
// -----------------------------------------------------------------------------
// preempt_arbiter
// Shares a single preemption slot among N intersection controllers. At most
// one grant bit is ever high. Round-robin fairness, ack handshake with
// timeout, minimum hold and forced revocation after a maximum hold.
//
// Build option: define PREEMPT_FIXED_PRIO_EN for fixed priority (index 0
// highest, no rotation; forced revocation only by a lower-index request).
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   req_i      [N]   level preemption request per intersection
//   ack_i      [N]   level "preempt active" acknowledge per intersection
//   grant_o    [N]   registered one-hot (or zero) grant
//   grant_id_o [IW]  index of current / last grant
//   busy_o           high whenever the FSM is not IDLE
//   timeout_err_o    one-cycle pulse when an ack does not arrive in time
// -----------------------------------------------------------------------------
module preempt_arbiter
    import preempt_pkg::*;
#(
    parameter int N           = 8,
    parameter int HOLD_TIME   = 1000,
    parameter int MAX_HOLD    = 4000,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N-1:0]              req_i,
    input  logic [N-1:0]              ack_i,
    output logic [N-1:0]              grant_o,
    output logic [idx_width(N)-1:0]   grant_id_o,
    output logic                      busy_o,
    output logic                      timeout_err_o
);

    localparam int IW = idx_width(N);

    localparam logic [CNT_W-1:0] HOLD_MIN_C = CNT_W'(HOLD_TIME - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ACK_LAST_C = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_q;
    logic [N-1:0]      grant_q;
    logic [IW-1:0]     gid_q;
    logic              busy_q;
    logic              terr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [IW-1:0]     pick_ptr;
    logic              found;
    logic [IW-1:0]     winner;

    logic [N-1:0]      gid_mask;
    logic [N-1:0]      contender_mask;
    logic              ack_g;
    logic              req_g;
    logic              others_pending;
    logic              ack_expired;
    logic              hold_release;
    logic              enter_release;

    assign gid_mask = {{(N-1){1'b0}}, 1'b1} << gid_q;
    assign ack_g    = ack_i[gid_q];
    assign req_g    = req_i[gid_q];

`ifdef PREEMPT_FIXED_PRIO_EN
    // Scan always starts at index 0; only a lower-index request may force
    // revocation of a long hold.
    assign pick_ptr       = '0;
    assign contender_mask = gid_mask - {{(N-1){1'b0}}, 1'b1};
`else
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Next scan starts just after the requester being released.
    assign ptr_d          = (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;
    assign pick_ptr       = ptr_q;
    assign contender_mask = ~gid_mask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (enter_release) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    rr_pick #(.N(N)) u_pick (
        .req_i    (req_i),
        .ptr_i    (pick_ptr),
        .found_o  (found),
        .winner_o (winner)
    );

    assign others_pending = |(req_i & contender_mask);
    assign ack_expired    = (cnt_q == ACK_LAST_C);

    // Minimum hold is enforced even if the requester drops early; the maximum
    // hold only bites when somebody else is actually waiting.
    assign hold_release = ((cnt_q >= HOLD_MIN_C) && !req_g) ||
                          ((cnt_q >= HOLD_MAX_C) && others_pending);

    assign enter_release = ((state_q == WAIT_ACK) && !ack_g && ack_expired) ||
                           ((state_q == HOLD) && hold_release);

    // Hold counter saturates so a very long hold cannot wrap back below the
    // release thresholds.
    assign cnt_d = (cnt_q >= HOLD_SAT_C) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            terr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= {{(N-1){1'b0}}, 1'b1} << winner;
                        gid_q   <= winner;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_g) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else if (ack_expired) begin
                        terr_q  <= 1'b1;
                        grant_q <= '0;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_release) begin
                        grant_q <= '0;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE: begin
                    // Wait for the controller to leave preempt mode so it never
                    // sees a fresh grant while its ack is still high.
                    if (!ack_g) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = gid_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = terr_q;

endmodule
